// File: rtl/sct_step_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sct_step_seq: registered step state with LOAD/STEP/RUN/STOP       |
// | command handshake feeding the sct decode stage.   Rev 1.0         |
// +------------------------------------------------------------------+
module sct_step_seq #(
  parameter int PRESCALE = 4,  // enabled cycles between RUN commits, 1..255
  parameter int STATE_W  = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [STATE_W-1:0] cmd_data,
  output logic [STATE_W-1:0] state_q,
  input  logic [STATE_W-1:0] nxt_d,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [15:0]        step_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } fsm_t;

  localparam logic [1:0] c_op_stop = 2'b00;
  localparam logic [1:0] c_op_load = 2'b01;
  localparam logic [1:0] c_op_step = 2'b10;
  localparam logic [1:0] c_op_run  = 2'b11;
  localparam logic [7:0] c_pc_last = 8'(PRESCALE - 1);

  fsm_t               r_fsm;
  logic [7:0]         r_pc;
  logic [STATE_W-1:0] r_state;
  logic [15:0]        r_cnt;
  logic               r_done;
  logic               r_err;

  fsm_t       w_fsm_nxt;
  logic [7:0] w_pc_nxt;
  logic       w_accept;
  logic       w_same;
  logic       w_commit;
  logic       w_load;
  logic       w_done_nxt;
  logic       w_err_nxt;

  assign cmd_ready = enable & ((r_fsm == ST_IDLE) | (r_fsm == ST_RUN));
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_same    = (nxt_d == r_state);

  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_pc_nxt   = r_pc;
    w_commit   = 1'b0;
    w_load     = 1'b0;
    w_done_nxt = 1'b0;
    w_err_nxt  = 1'b0;
    if (enable) begin
      case (r_fsm)
        ST_IDLE: begin
          if (w_accept) begin
            case (cmd_op)
              c_op_load: begin
                w_load     = 1'b1;
                w_done_nxt = 1'b1;
              end
              c_op_step: w_fsm_nxt = ST_SETTLE;
              c_op_run: begin
                w_fsm_nxt = ST_RUN;
                w_pc_nxt  = 8'd0;
              end
              default: ;
            endcase
          end
        end
        ST_SETTLE: begin
          w_commit   = 1'b1;
          w_done_nxt = 1'b1;
          w_fsm_nxt  = ST_IDLE;
        end
        ST_RUN: begin
          // STOP pre-empts a commit due on the same edge
          if (w_accept && (cmd_op == c_op_stop)) begin
            w_fsm_nxt  = ST_IDLE;
            w_done_nxt = 1'b1;
          end else begin
            w_err_nxt = w_accept;
            if (r_pc == c_pc_last) begin
              w_commit = 1'b1;
              w_pc_nxt = 8'd0;
              if (w_same) begin
                w_fsm_nxt  = ST_IDLE;
                w_done_nxt = 1'b1;
              end
            end else begin
              w_pc_nxt = r_pc + 8'd1;
            end
          end
        end
        default: w_fsm_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm   <= ST_IDLE;
      r_pc    <= 8'd0;
      r_state <= '0;
      r_cnt   <= 16'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_fsm  <= w_fsm_nxt;
      r_pc   <= w_pc_nxt;
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
      if (w_load) begin
        r_state <= cmd_data;
        r_cnt   <= 16'd0;
      end else if (w_commit) begin
        r_state <= nxt_d;
        if (!w_same && (r_cnt != 16'hFFFF)) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

  assign state_q  = r_state;
  assign step_cnt = r_cnt;
  assign busy     = (r_fsm == ST_SETTLE) | (r_fsm == ST_RUN);
  assign done     = r_done;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sct_step_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sct_step_seq: directed/randomized bench for sct_step_seq.      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_sct_step_seq;

  localparam logic [1:0] c_stop = 2'b00;
  localparam logic [1:0] c_load = 2'b01;
  localparam logic [1:0] c_step = 2'b10;
  localparam logic [1:0] c_run  = 2'b11;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable, cmd_valid, cmd_ready, busy, done, err;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data, state_q, nxt_d;
  logic [15:0] step_cnt;

  logic        enable2, cmd_valid2, cmd_ready2, busy2, done2, err2;
  logic [1:0]  cmd_op2;
  logic [7:0]  cmd_data2, state_q2, nxt_d2;
  logic [15:0] step_cnt2;

  // decode-stage stand-in: 0 = increment, 1 = fixed value, 2 = increment until fp
  int         nxt_mode;
  logic [7:0] nxt_val, fp;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  assign nxt_d  = (nxt_mode == 1) ? nxt_val :
                  ((nxt_mode == 2) && (state_q == fp)) ? state_q : state_q + 8'd1;
  assign nxt_d2 = state_q2 + 8'd1;

  sct_step_seq #(.PRESCALE(4), .STATE_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data), .state_q(state_q),
    .nxt_d(nxt_d), .busy(busy), .done(done), .err(err), .step_cnt(step_cnt)
  );

  sct_step_seq #(.PRESCALE(1), .STATE_W(8)) dut2 (
    .clock(clock), .reset_n(reset_n), .enable(enable2), .cmd_valid(cmd_valid2),
    .cmd_ready(cmd_ready2), .cmd_op(cmd_op2), .cmd_data(cmd_data2), .state_q(state_q2),
    .nxt_d(nxt_d2), .busy(busy2), .done(done2), .err(err2), .step_cnt(step_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cmd(input logic v, input logic [1:0] op, input logic [7:0] d);
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = d;
  endtask

  initial begin
    logic [7:0]  s, v, ex, exp_state;
    logic [15:0] exp_cnt;
    int          e;
    logic        en;

    reset_n = 1'b0; enable = 1'b0; nxt_mode = 0; nxt_val = 8'd0; fp = 8'd0;
    cmd(1'b0, c_stop, 8'd0);
    enable2 = 1'b0; cmd_valid2 = 1'b0; cmd_op2 = c_stop; cmd_data2 = 8'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_state", 32'(state_q), 32'h0);
    chk("rst_cnt", 32'(step_cnt), 32'h0);
    chk("rst_ready", 32'(cmd_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    reset_n = 1'b1; enable = 1'b1; enable2 = 1'b1;
    #1 chk("idle_ready", 32'(cmd_ready), 32'h1);
    tick();

    // LOAD, then asynchronous reset mid-cycle
    cmd(1'b1, c_load, 8'h5A); tick(); cmd(1'b0, c_stop, 8'd0);
    chk("load_state", 32'(state_q), 32'h5A);
    chk("load_done", 32'(done), 32'h1);
    chk("load_cnt", 32'(step_cnt), 32'h0);
    tick();
    chk("load_done_clr", 32'(done), 32'h0);
    #2 reset_n = 1'b0;
    #1 chk("async_rst_state", 32'(state_q), 32'h0);
    #1 reset_n = 1'b1;
    tick();
    cmd(1'b1, c_load, 8'h5A); tick(); cmd(1'b0, c_stop, 8'd0);
    chk("reload_state", 32'(state_q), 32'h5A);

    // single STEP
    nxt_mode = 1; nxt_val = 8'h5B;
    cmd(1'b1, c_step, 8'd0); tick(); cmd(1'b0, c_stop, 8'd0);
    chk("settle_ready", 32'(cmd_ready), 32'h0);
    chk("settle_busy", 32'(busy), 32'h1);
    chk("settle_state", 32'(state_q), 32'h5A);
    tick();
    chk("step_state", 32'(state_q), 32'h5B);
    chk("step_cnt", 32'(step_cnt), 32'h1);
    chk("step_done", 32'(done), 32'h1);
    chk("step_ready", 32'(cmd_ready), 32'h1);
    exp_state = 8'h5B; exp_cnt = 16'd1;

    // random LOAD/STEP mix, some STEPs hitting a fixed point
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        v = 8'($urandom);
        cmd(1'b1, c_load, v); tick(); cmd(1'b0, c_stop, 8'd0);
        exp_state = v; exp_cnt = 16'd0;
      end else begin
        v = ($urandom_range(0, 2) == 0) ? exp_state : 8'($urandom);
        nxt_val = v;
        cmd(1'b1, c_step, 8'd0); tick(); cmd(1'b0, c_stop, 8'd0);
        chk("rnd_settle", 32'(state_q), 32'(exp_state));
        tick();
        if (v != exp_state) exp_cnt = exp_cnt + 16'd1;
        exp_state = v;
      end
      chk("rnd_state", 32'(state_q), 32'(exp_state));
      chk("rnd_cnt", 32'(step_cnt), 32'(exp_cnt));
      chk("rnd_done", 32'(done), 32'h1);
    end

    // RUN with increment model, STOP on the edge where a commit is due
    nxt_mode = 0; s = exp_state;
    cmd(1'b1, c_run, 8'd0); tick(); cmd(1'b0, c_stop, 8'd0);
    for (int k = 1; k <= 12; k++) begin
      if (k == 12) cmd(1'b1, c_stop, 8'd0);
      tick(); cmd(1'b0, c_stop, 8'd0);
      ex = s + 8'((k == 12) ? 2 : k / 4);
      chk("run_state", 32'(state_q), 32'(ex));
      chk("run_done", 32'(done), (k == 12) ? 32'h1 : 32'h0);
      chk("run_busy", 32'(busy), (k == 12) ? 32'h0 : 32'h1);
    end
    chk("run_cnt", 32'(step_cnt), 32'(exp_cnt + 16'd2));
    tick();
    chk("run_no3rd", 32'(state_q), 32'(s + 8'd2));
    chk("run_done_clr", 32'(done), 32'h0);

    // RUN to a fixed point at the 3rd commit, illegal LOAD on that same edge
    s = 8'($urandom);
    cmd(1'b1, c_load, s); tick(); cmd(1'b0, c_stop, 8'd0);
    nxt_mode = 2; fp = s + 8'd2;
    cmd(1'b1, c_run, 8'd0); tick(); cmd(1'b0, c_stop, 8'd0);
    for (int k = 1; k <= 12; k++) begin
      if (k == 12) cmd(1'b1, c_load, 8'hFF);
      tick(); cmd(1'b0, c_stop, 8'd0);
      if (k < 12) begin
        chk("fp_state", 32'(state_q), 32'(s + 8'(k / 4)));
        chk("fp_busy", 32'(busy), 32'h1);
      end
    end
    chk("fp_state_end", 32'(state_q), 32'(s + 8'd2));
    chk("fp_done", 32'(done), 32'h1);
    chk("fp_err", 32'(err), 32'h1);
    chk("fp_busy_end", 32'(busy), 32'h0);
    chk("fp_cnt", 32'(step_cnt), 32'h2);
    tick();
    chk("fp_done_clr", 32'(done), 32'h0);
    chk("fp_err_clr", 32'(err), 32'h0);

    // RUN with illegal commands and an enable stall of 3 cycles
    nxt_mode = 0; s = 8'($urandom);
    cmd(1'b1, c_load, s); tick(); cmd(1'b0, c_stop, 8'd0);
    cmd(1'b1, c_run, 8'd0); tick(); cmd(1'b0, c_stop, 8'd0);
    e = 0;
    for (int k = 1; k <= 14; k++) begin
      en = !(k >= 5 && k <= 7);
      enable = en;
      if (k == 2) cmd(1'b1, c_load, 8'hFF);
      else if (!en) cmd(1'b1, c_stop, 8'd0);
      else if (k == 11) cmd(1'b1, c_run, 8'd0);
      else cmd(1'b0, c_stop, 8'd0);
      #1 chk("stall_ready", 32'(cmd_ready), 32'(en));
      tick(); cmd(1'b0, c_stop, 8'd0);
      if (en) e++;
      chk("stall_state", 32'(state_q), 32'(s + 8'(e / 4)));
      chk("stall_err", 32'(err), (k == 2 || k == 11) ? 32'h1 : 32'h0);
      chk("stall_done", 32'(done), 32'h0);
    end
    cmd(1'b1, c_stop, 8'd0); tick(); cmd(1'b0, c_stop, 8'd0);
    chk("stop_wins_state", 32'(state_q), 32'(s + 8'(e / 4)));
    chk("stop_done", 32'(done), 32'h1);
    chk("stop_busy", 32'(busy), 32'h0);
    chk("stall_cnt", 32'(step_cnt), 32'h2);

    // step_cnt saturation on a PRESCALE=1 instance
    cmd_valid2 = 1'b1; cmd_op2 = c_load; cmd_data2 = 8'h00; tick();
    cmd_op2 = c_run; tick();
    cmd_valid2 = 1'b0; cmd_op2 = c_stop;
    for (int k = 1; k <= 65539; k++) begin
      if (k == 65539) begin cmd_valid2 = 1'b1; cmd_op2 = c_stop; end
      tick(); cmd_valid2 = 1'b0;
      if (k == 65534) chk("sat_fffe", 32'(step_cnt2), 32'hFFFE);
      if (k == 65535) begin
        chk("sat_ffff", 32'(step_cnt2), 32'hFFFF);
        chk("sat_state_a", 32'(state_q2), 32'hFF);
      end
      if (k == 65538) begin
        chk("sat_hold", 32'(step_cnt2), 32'hFFFF);
        chk("sat_state_b", 32'(state_q2), 32'h02);
      end
    end
    chk("sat_stop_state", 32'(state_q2), 32'h02);
    chk("sat_stop_done", 32'(done2), 32'h1);
    chk("sat_stop_cnt", 32'(step_cnt2), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sct_step_seq.md
# sct_step_seq

Sequential state-holding stage placed directly upstream of the combinational `sct` decode stage. It registers the 8-bit step state that feeds the decode logic and accepts commands through a valid/ready handshake: load, single step, free run, stop. Each commit captures the decode stage's next-state word back into the register, closing the loop. It also tracks the number of committed steps and flags fixed points and illegal commands.

## Interface
- `PRESCALE`, 4: enabled cycles between commits in RUN mode. Legal range is 1..255.
- `STATE_W`, 8: width of the state word. Fixed at 8; any other value is illegal.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: global advance enable. When low, the block is frozen.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready` at a rising edge.
- `cmd_op` in 2: command code. 00 = STOP/NOP, 01 = LOAD, 10 = STEP, 11 = RUN.
- `cmd_data` in 8: load value, used only by LOAD.
- `state_q` out 8: registered state, driven to the decode stage.
- `nxt_d` in 8: next-state word returned combinationally by the decode stage.
- `busy` out 1: high in SETTLE and RUN.
- `done` out 1: one-cycle pulse on completion.
- `err` out 1: one-cycle pulse on an illegal command.
- `step_cnt` out 16: committed-step count, saturating.

## Operation
- Reset values of outputs: `state_q` = 0x00, `step_cnt` = 0, `cmd_ready` = 0, `busy` = 0, `done` = 0, `err` = 0. FSM state = IDLE. Prescaler `pc` = 0.
- `cmd_ready` = `enable & (fsm==IDLE | fsm==RUN)`. It is a combinational function of registered state and `enable` only; it never depends on `cmd_valid`.
- `enable` low:
  - no state changes and no commands accepted;
  - `pc`, `state_q` and `step_cnt` hold;
  - `done` and `err` are forced to 0.
- The FSM has three states: IDLE, SETTLE, RUN.
- In IDLE, on an accepted command:
  - LOAD: `state_q` <= `cmd_data`, `step_cnt` <= 0; stay in IDLE; `done` pulses.
  - STEP: go to SETTLE. This gives the decode stage one full cycle to settle.
  - RUN: go to RUN with `pc` <= 0.
  - STOP/NOP: no action; no pulse.
- In SETTLE, on the next enabled edge:
  - commit (see commit rule below) and return to IDLE;
  - `done` pulses whether or not a fixed point was hit.
- In RUN:
  - `pc` increments on each enabled edge.
  - When `pc == PRESCALE-1`: commit and set `pc` <= 0.
  - If that commit sees `nxt_d == state_q` (fixed point): go to IDLE and pulse `done`.
  - Accepted STOP: go to IDLE immediately and pulse `done`. No commit happens on that edge, even if `pc` is terminal; STOP wins.
  - Accepted LOAD, STEP or RUN: the command is consumed and dropped, `err` pulses, and RUN continues unaffected (including a commit on the same edge).
- Commit rule:
  - `state_q` <= `nxt_d`.
  - `step_cnt` increments by 1 only if `nxt_d != state_q`.
  - `step_cnt` saturates at 0xFFFF and never wraps.
- `nxt_d` is sampled only on commit edges. At all other times it is don't-care.
- Asserting reset mid-operation (SETTLE or RUN) aborts without a commit. All outputs take their reset values asynchronously. No `done` pulse is produced.

## Timing
- LOAD accepted at edge N: `state_q` = `cmd_data` and `done` = 1 in cycle N+1.
- STEP accepted at edge N: SETTLE during cycle N+1; commit at edge N+1; new `state_q` and `done` = 1 in cycle N+2. `cmd_ready` is low in cycle N+1.
- RUN accepted at edge N: first commit at edge N+PRESCALE (with `enable` held high), then every PRESCALE enabled edges.
  - PRESCALE = 1 commits on every enabled edge.
  - Cycles with `enable` low stretch the interval one-for-one.
- `done` and `err` are registered pulses, exactly one cycle wide.
- `done` and `err` never assert in the same cycle, except when an illegal command is accepted on the same edge as a RUN fixed-point exit. In that case both pulse.
- No combinational path runs from `nxt_d` to any output. `state_q` is driven directly from a flop.

## Test plan
- Reset, then LOAD 0x5A: `state_q` = 0x5A, `step_cnt` = 0, and `done` is high for 1 cycle, one cycle after acceptance. Assert `reset_n` low mid-cycle: `state_q` = 0x00 immediately.
- From 0x5A, STEP with the model returning `nxt_d` = 0x5B: `cmd_ready` is low for 1 cycle; `state_q` = 0x5B two cycles after acceptance; `step_cnt` = 1.
- RUN with PRESCALE = 4 and the model returning `state_q+1`: commits at edges N+4, N+8, N+12. Send STOP between N+8 and N+12, timed to the edge where `pc` = 3: `state_q` = start+2 and no third commit.
- RUN with the model returning `nxt_d` = `state_q` at the 3rd commit: FSM exits to IDLE with `done` pulsed and `step_cnt` = 2.
- During RUN, offer LOAD 0xFF: it is accepted, `err` pulses once, `state_q` is not loaded, and the commit cadence is unchanged. Toggle `enable` low for 3 cycles: the next commit is delayed exactly 3 cycles and `cmd_ready` is low throughout.
- Preload `step_cnt` to 0xFFFE via 2 STEPs after forcing, then 3 more changing STEPs: `step_cnt` holds at 0xFFFF.
